systolic_input_feeder: RTL and testbench
========================================

Name: systolic_input_feeder

Overview:
- Upstream stage of the 2x2 weight-stationary systolic array. Accepts one 2x2 activation tile plus optional weights through a valid/ready handshake.
- Optionally presents the weights with a one-cycle load_weights pulse, then streams the tile into the array's two activation lanes with diagonal (one-cycle) skew. Pulses start on the first feed cycle.
- Holds off the next tile until the array has drained, then pulses done.

Parameters:
- DATA_WIDTH, 16, width of every activation and weight element.
- DRAIN_CYCLES, 3, idle cycles after the last feed beat before done; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tile_valid  input  1  upstream offers a tile.
- tile_ready  output  1  feeder can accept a tile; high only in IDLE.
- tile_load_w  input  1  tile carries new weights; sampled with the tile.
- x11, x12, x21, x22  input  DATA_WIDTH each  activation tile elements (row, column).
- w11, w12, w21, w22  input  DATA_WIDTH each  weights; sampled with the tile.
- w11_o, w12_o, w21_o, w22_o  output  DATA_WIDTH each  registered weights to the array.
- load_weights  output  1  one-cycle weight-load strobe to the array.
- start  output  1  one-cycle strobe in the first feed cycle.
- lane0, lane1  output  DATA_WIDTH each  skewed activation streams (array rows 0/1).
- lane0_v, lane1_v  output  1 each  lane data valid.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle strobe when the tile is fully drained.

Behaviour:
- Reset: state IDLE. All data outputs, w*_o, strobes, valids, busy and done are 0. tile_ready is 1 in the first cycle after reset.
- Reset mid-operation takes effect at the next edge regardless of state. The captured tile is discarded; no done is issued.
- Handshake: the tile is accepted on an edge where tile_valid && tile_ready. All x*, w* and tile_load_w are captured into internal registers on that edge. Inputs are don't-care at all other times.
- No downstream backpressure exists; once accepted, the sequence runs to completion.
- States:
  - IDLE: tile_ready=1. On accept, go to LOAD if tile_load_w=1, else FEED (cnt=0).
  - LOAD: lasts 1 cycle. load_weights=1; w*_o show the captured weights. Then go to FEED (cnt=0).
  - FEED: lasts 3 cycles, cnt 0..2. Then go to DRAIN (cnt=0).
  - DRAIN: lasts DRAIN_CYCLES cycles; lanes are 0 with valids 0. Then go to DONE.
  - DONE: lasts 1 cycle with done=1. Then go to IDLE.
- w*_o registers update only on a LOAD state. When tile_load_w=0 they keep their previous value, so weights persist across tiles.
- FEED lane schedule (all outputs registered, driven by the current state; skew makes lane1 lag lane0 by one cycle):
  - F0: lane0=x11, lane0_v=1; lane1=0, lane1_v=0; start=1.
  - F1: lane0=x21, lane0_v=1; lane1=x12, lane1_v=1.
  - F2: lane0=0, lane0_v=0; lane1=x22, lane1_v=1.
- Outside F0..F2, lanes are 0 and valids are 0 (zero padding into the array).
- Latency from accept edge to F0 is 1 cycle without load, 2 cycles with load.
- Total busy cycles = 3 + DRAIN_CYCLES + 1, plus 1 when loading weights.
- The next accept is possible in the cycle after DONE (IDLE). A tile_valid held high back-to-back is therefore accepted every 3+DRAIN_CYCLES+2 cycles when not loading weights.
- A single shared counter serves FEED and DRAIN. It is 4 bits wide and resets to 0 on every state change.
- No arithmetic is performed; values pass bit-exact and unsigned-agnostic.
- done and tile_ready are never high in the same cycle.

Decomposition:
- Shared package systolic_pkg holds:
  - ARRAY_DIM = 2.
  - FEED_BEATS = 2*ARRAY_DIM-1.
  - Feeder state enum {IDLE, LOAD, FEED, DRAIN, DONE}.
- No sub-module; a single FSM with a counter and capture registers is the natural size.

Test Plan:
- Reset then idle: assert reset for 2 cycles -> every output 0, then tile_ready=1 and busy=0 on the first cycle after reset deasserts.
- Basic feed, no load:
  - Stimulus: accept x11=1, x12=2, x21=3, x22=4, tile_load_w=0 at edge k.
  - Required cycles: k+1 lane0=1 (v), start=1; k+2 lane0=3, lane1=2 (both v); k+3 lane1=4 (v1 only).
  - Then 3 zero cycles, done=1 at cycle k+7, tile_ready=1 at k+8; load_weights never asserted.
- Weight load:
  - Stimulus: accept with tile_load_w=1, w11=0x0A, w12=0x0B, w21=0x0C, w22=0x0D.
  - Required: load_weights=1 exactly one cycle with w*_o=0A/0B/0C/0D, start in the following cycle.
  - A subsequent tile with tile_load_w=0 and w inputs=0xFF leaves w*_o at 0A..0D.
- Back-pressure: hold tile_valid=1 with changing data during busy -> no capture. tile_ready=0 throughout; the second tile is accepted only in IDLE after done, and its values appear on the lanes.
- Reset mid-feed: assert reset in F1 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh tile then feeds normally.
- DRAIN_CYCLES=1 variant: basic tile -> done asserted 5 cycles after the accept edge.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and the feeder state type for the 2x2 weight-stationary array.
package systolic_pkg;
   localparam int ARRAY_DIM  = 2;
   localparam int FEED_BEATS = 2*ARRAY_DIM-1;

   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} feeder_state_t;
endpackage

// File: rtl/systolic_input_feeder.sv
// Accepts one 2x2 activation tile (plus optional weights) and streams it into the
// array's two lanes with one-cycle diagonal skew, then waits out the drain.
module systolic_input_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tile_valid,
   output logic                  tile_ready,
   input  logic                  tile_load_w,
   input  logic [DATA_WIDTH-1:0] x11,
   input  logic [DATA_WIDTH-1:0] x12,
   input  logic [DATA_WIDTH-1:0] x21,
   input  logic [DATA_WIDTH-1:0] x22,
   input  logic [DATA_WIDTH-1:0] w11,
   input  logic [DATA_WIDTH-1:0] w12,
   input  logic [DATA_WIDTH-1:0] w21,
   input  logic [DATA_WIDTH-1:0] w22,
   output logic [DATA_WIDTH-1:0] w11_o,
   output logic [DATA_WIDTH-1:0] w12_o,
   output logic [DATA_WIDTH-1:0] w21_o,
   output logic [DATA_WIDTH-1:0] w22_o,
   output logic                  load_weights,
   output logic                  start,
   output logic [DATA_WIDTH-1:0] lane0,
   output logic [DATA_WIDTH-1:0] lane1,
   output logic                  lane0_v,
   output logic                  lane1_v,
   output logic                  busy,
   output logic                  done
);

   localparam logic [3:0] FEED_LAST  = 4'(FEED_BEATS-1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES-1);

   feeder_state_t         state;
   logic [3:0]            cnt;
   logic [DATA_WIDTH-1:0] x11_q, x12_q, x21_q, x22_q;
   logic                  accept;

   // Ready is masked by reset so nothing is offered while reset is held.
   assign tile_ready = (state == IDLE) && !reset;
   assign busy       = (state != IDLE);
   assign accept     = tile_valid && tile_ready;

   // Outputs are registered from the next state, so each edge sets up the
   // values seen during the cycle spent in the state it enters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         x11_q        <= '0;
         x12_q        <= '0;
         x21_q        <= '0;
         x22_q        <= '0;
         w11_o        <= '0;
         w12_o        <= '0;
         w21_o        <= '0;
         w22_o        <= '0;
         load_weights <= 1'b0;
         start        <= 1'b0;
         lane0        <= '0;
         lane1        <= '0;
         lane0_v      <= 1'b0;
         lane1_v      <= 1'b0;
         done         <= 1'b0;
      end else begin
         load_weights <= 1'b0;
         start        <= 1'b0;
         lane0        <= '0;
         lane1        <= '0;
         lane0_v      <= 1'b0;
         lane1_v      <= 1'b0;
         done         <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  x11_q <= x11;
                  x12_q <= x12;
                  x21_q <= x21;
                  x22_q <= x22;
                  cnt   <= '0;
                  if (tile_load_w) begin
                     state        <= LOAD;
                     load_weights <= 1'b1;
                     w11_o        <= w11;
                     w12_o        <= w12;
                     w21_o        <= w21;
                     w22_o        <= w22;
                  end else begin
                     state   <= FEED;
                     start   <= 1'b1;
                     lane0   <= x11;
                     lane0_v <= 1'b1;
                  end
               end
            end
            LOAD: begin
               state   <= FEED;
               cnt     <= '0;
               start   <= 1'b1;
               lane0   <= x11_q;
               lane0_v <= 1'b1;
            end
            FEED: begin
               if (cnt == FEED_LAST) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 4'd1;
                  // cnt is the beat being left; set up the next skewed beat.
                  if (cnt == 4'd0) begin
                     lane0   <= x21_q;
                     lane0_v <= 1'b1;
                     lane1   <= x12_q;
                     lane1_v <= 1'b1;
                  end else begin
                     lane1   <= x22_q;
                     lane1_v <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state <= DONE;
                  cnt   <= '0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Randomized directed bench for systolic_input_feeder against a tile-level frame model.
module tb_systolic_input_feeder;
   localparam int DW = 16;

   typedef struct {
      logic          lw, st, l0v, l1v, dn, bs, rd;
      logic [DW-1:0] l0, l1;
      logic [DW-1:0] w [4];
   } frame_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tv [2];
   logic          tlw = 1'b0;
   logic [DW-1:0] xi [4];
   logic [DW-1:0] wi [4];

   logic          rdy [2], lw [2], st [2], l0v [2], l1v [2], bs [2], dn [2];
   logic [DW-1:0] l0 [2], l1 [2];
   logic [DW-1:0] wo [2][4];

   logic [DW-1:0] wref [2][4];
   int            n_assert = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   systolic_input_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(3)) dut_a (
      .clk(clk), .reset(reset), .tile_valid(tv[0]), .tile_ready(rdy[0]),
      .tile_load_w(tlw),
      .x11(xi[0]), .x12(xi[1]), .x21(xi[2]), .x22(xi[3]),
      .w11(wi[0]), .w12(wi[1]), .w21(wi[2]), .w22(wi[3]),
      .w11_o(wo[0][0]), .w12_o(wo[0][1]), .w21_o(wo[0][2]), .w22_o(wo[0][3]),
      .load_weights(lw[0]), .start(st[0]), .lane0(l0[0]), .lane1(l1[0]),
      .lane0_v(l0v[0]), .lane1_v(l1v[0]), .busy(bs[0]), .done(dn[0])
   );

   systolic_input_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .tile_valid(tv[1]), .tile_ready(rdy[1]),
      .tile_load_w(tlw),
      .x11(xi[0]), .x12(xi[1]), .x21(xi[2]), .x22(xi[3]),
      .w11(wi[0]), .w12(wi[1]), .w21(wi[2]), .w22(wi[3]),
      .w11_o(wo[1][0]), .w12_o(wo[1][1]), .w21_o(wo[1][2]), .w22_o(wo[1][3]),
      .load_weights(lw[1]), .start(st[1]), .lane0(l0[1]), .lane1(l1[1]),
      .lane0_v(l0v[1]), .lane1_v(l1v[1]), .busy(bs[1]), .done(dn[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic frame_t sample(input int s);
      frame_t f;
      f.lw = lw[s];  f.st = st[s];   f.l0v = l0v[s]; f.l1v = l1v[s];
      f.dn = dn[s];  f.bs = bs[s];   f.rd = rdy[s];
      f.l0 = l0[s];  f.l1 = l1[s];
      for (int i = 0; i < 4; i++) f.w[i] = wo[s][i];
      return f;
   endfunction

   function automatic frame_t quiet(input int s, input logic ready);
      frame_t f;
      f.lw = 0; f.st = 0; f.l0v = 0; f.l1v = 0; f.dn = 0; f.bs = 0; f.rd = ready;
      f.l0 = '0; f.l1 = '0;
      for (int i = 0; i < 4; i++) f.w[i] = wref[s][i];
      return f;
   endfunction

   task automatic check_frame(input string tag, input frame_t o, input frame_t e);
      chk({tag, ".load_weights"}, 32'(o.lw), 32'(e.lw));
      chk({tag, ".start"},        32'(o.st), 32'(e.st));
      chk({tag, ".lane0"},        32'(o.l0), 32'(e.l0));
      chk({tag, ".lane0_v"},      32'(o.l0v), 32'(e.l0v));
      chk({tag, ".lane1"},        32'(o.l1), 32'(e.l1));
      chk({tag, ".lane1_v"},      32'(o.l1v), 32'(e.l1v));
      chk({tag, ".done"},         32'(o.dn), 32'(e.dn));
      chk({tag, ".busy"},         32'(o.bs), 32'(e.bs));
      chk({tag, ".tile_ready"},   32'(o.rd), 32'(e.rd));
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s.w_o[%0d]", tag, i), 32'(o.w[i]), 32'(e.w[i]));
   endtask

   // Run one tile through feeder s starting at a negedge in IDLE. x is row-major
   // {x11,x12,x21,x22}. With hold set, tile_valid stays high with junk data.
   task automatic run_tile(input string tag, input int s, input logic [DW-1:0] x [4],
                           input logic [DW-1:0] w [4], input logic load,
                           input logic hold, input int drain);
      frame_t q[$];
      frame_t f;
      for (int i = 0; i < 4; i++) begin xi[i] = x[i]; wi[i] = w[i]; end
      tlw = load;
      tv[s] = 1'b1;
      if (load) begin
         for (int i = 0; i < 4; i++) wref[s][i] = w[i];
         f = quiet(s, 0); f.bs = 1; f.lw = 1;
         q.push_back(f);
      end
      // Lane c carries column c; at beat b it shows row b-c when that row exists.
      for (int b = 0; b < 3; b++) begin
         f = quiet(s, 0); f.bs = 1; f.st = (b == 0);
         if (b < 2)           begin f.l0 = x[b*2];         f.l0v = 1; end
         if (b >= 1 && b < 3) begin f.l1 = x[(b-1)*2 + 1]; f.l1v = 1; end
         q.push_back(f);
      end
      for (int d = 0; d < drain; d++) begin
         f = quiet(s, 0); f.bs = 1;
         q.push_back(f);
      end
      f = quiet(s, 0); f.bs = 1; f.dn = 1;
      q.push_back(f);

      @(posedge clk);
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         if (hold) begin
            for (int i = 0; i < 4; i++) begin xi[i] = DW'($urandom); wi[i] = DW'($urandom); end
            tlw = 1'($urandom);
         end else begin
            tv[s] = 1'b0;
         end
         check_frame($sformatf("%s.c%0d", tag, k + 1), sample(s), q[k]);
      end
      @(negedge clk);
      check_frame({tag, ".idle"}, sample(s), quiet(s, 1));
   endtask

   logic [DW-1:0] xa [4];
   logic [DW-1:0] wa [4];

   initial begin
      tv[0] = 1'b0; tv[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin xi[i] = '0; wi[i] = '0; wref[0][i] = '0; wref[1][i] = '0; end

      // Reset held for two edges: everything quiet, not ready.
      @(negedge clk); @(negedge clk);
      check_frame("rst_a", sample(0), quiet(0, 0));
      check_frame("rst_b", sample(1), quiet(1, 0));
      reset = 1'b0;
      #1;
      chk("rst_rel.ready", 32'(rdy[0]), 32'd1);
      chk("rst_rel.busy",  32'(bs[0]),  32'd0);

      // Basic feed without weights.
      xa = '{16'd1, 16'd2, 16'd3, 16'd4};
      wa = '{16'h55, 16'h66, 16'h77, 16'h88};
      run_tile("basic", 0, xa, wa, 1'b0, 1'b0, 3);

      // Weight load.
      xa = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      wa = '{16'h0A, 16'h0B, 16'h0C, 16'h0D};
      run_tile("wload", 0, xa, wa, 1'b1, 1'b0, 3);

      // Weights persist when the next tile does not load.
      xa = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
      wa = '{16'hFF, 16'hFF, 16'hFF, 16'hFF};
      run_tile("wkeep", 0, xa, wa, 1'b0, 1'b0, 3);

      // Valid held high across a busy tile: only the IDLE offer is captured.
      for (int i = 0; i < 4; i++) begin xa[i] = DW'($urandom); wa[i] = DW'($urandom); end
      run_tile("hold1", 0, xa, wa, 1'b1, 1'b1, 3);
      for (int i = 0; i < 4; i++) begin xa[i] = DW'($urandom); wa[i] = DW'($urandom); end
      run_tile("hold2", 0, xa, wa, 1'b0, 1'b0, 3);

      // Random tiles with random load choice.
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 4; i++) begin xa[i] = DW'($urandom); wa[i] = DW'($urandom); end
         run_tile($sformatf("rnd%0d", t), 0, xa, wa, 1'($urandom), 1'b0, 3);
      end

      // Reset asserted during the second feed beat.
      xa = '{16'hA1, 16'hA2, 16'hA3, 16'hA4};
      for (int i = 0; i < 4; i++) xi[i] = xa[i];
      tlw = 1'b0; tv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk); tv[0] = 1'b0;
      chk("mid.f0_start", 32'(st[0]), 32'd1);
      chk("mid.f0_lane0", 32'(l0[0]), 32'hA1);
      @(negedge clk);
      chk("mid.f1_lane1", 32'(l1[0]), 32'hA2);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin wref[0][i] = '0; wref[1][i] = '0; end
      @(negedge clk);
      check_frame("mid.rst", sample(0), quiet(0, 0));
      reset = 1'b0;
      #1;
      chk("mid.ready", 32'(rdy[0]), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("mid.nodone%0d", k), 32'(dn[0]), 32'd0);
         chk($sformatf("mid.idle%0d", k),   32'(bs[0]), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin xa[i] = DW'($urandom); wa[i] = DW'($urandom); end
      run_tile("fresh", 0, xa, wa, 1'b0, 1'b0, 3);

      // Short drain variant: done lands 5 cycles after the accept edge.
      xa = '{16'd1, 16'd2, 16'd3, 16'd4};
      wa = '{16'd0, 16'd0, 16'd0, 16'd0};
      run_tile("drain1", 1, xa, wa, 1'b0, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin xa[i] = DW'($urandom); wa[i] = DW'($urandom); end
      run_tile("drain1w", 1, xa, wa, 1'b1, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
